// File: rtl/simple_router_2x2.sv
// simple_router_2x2: 2x2 wormhole flit router with per-input FIFOs and per-output round-robin arbiters.
// Route locks and output ownership are the same fact: an input mid-packet owns its target output.
package simple_router_2x2_pkg;
    localparam int DATA_W = 32;
    typedef struct packed {
        logic              head;
        logic              tail;
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              output_port_num;
        logic              txn_id;
    } pkt_flit_t;
endpackage

module simple_router_2x2
    import simple_router_2x2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    input  pkt_flit_t [1:0] pkt_in,
    output pkt_flit_t [1:0] pkt_out,
    output logic      [1:0] fifo_full
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    pkt_flit_t       r_mem [2][FIFO_DEPTH];
    logic [AW-1:0]   r_wp [2];
    logic [AW-1:0]   r_rp [2];
    logic [CW-1:0]   r_cnt [2];
    logic [1:0]      r_act;
    logic [1:0]      r_tgt;
    logic [1:0]      r_pri;

    pkt_flit_t [1:0] w_head;
    logic [1:0]      w_empty;
    logic [1:0]      w_tgt;
    logic [1:0]      w_push;
    logic [1:0]      w_pop;
    logic [1:0][1:0] w_req;
    logic [1:0]      w_own_v;
    logic [1:0]      w_gi;
    logic [1:0]      w_gv;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_head[i]    = r_mem[i][r_rp[i]];
            w_empty[i]   = r_cnt[i] == '0;
            fifo_full[i] = r_cnt[i] == CW'(FIFO_DEPTH);
            w_tgt[i]     = r_act[i] ? r_tgt[i] : w_head[i].output_port_num;
            w_push[i]    = pkt_in[i].valid && !fifo_full[i];
        end
        for (int o = 0; o < 2; o++) begin
            for (int i = 0; i < 2; i++)
                w_req[o][i] = !w_empty[i] && w_tgt[i] == 1'(o);
            w_own_v[o] = (r_act[0] && r_tgt[0] == 1'(o)) || (r_act[1] && r_tgt[1] == 1'(o));
            // an owned output only serves its owner, even while the owner's FIFO is empty
            w_gi[o]    = w_own_v[o] ? (r_act[1] && r_tgt[1] == 1'(o))
                                    : (&w_req[o] ? r_pri[o] : w_req[o][1]);
            w_gv[o]    = w_req[o][w_gi[o]];
        end
        for (int i = 0; i < 2; i++)
            w_pop[i] = w_gv[w_tgt[i]] && w_gi[w_tgt[i]] == 1'(i);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i]) r_mem[i][r_wp[i]] <= pkt_in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            for (int i = 0; i < 2; i++) begin
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_cnt[i] <= '0;
            end
            r_act   <= '0;
            r_tgt   <= '0;
            r_pri   <= '0;
            pkt_out <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_push[i]) r_wp[i] <= r_wp[i] + 1'b1;
                if (w_pop[i]) begin
                    r_rp[i]  <= r_rp[i] + 1'b1;
                    r_act[i] <= !w_head[i].tail;
                    r_tgt[i] <= w_tgt[i];
                end
                r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
            end
            for (int o = 0; o < 2; o++) begin
                pkt_out[o] <= w_gv[o] ? w_head[w_gi[o]] : '0;
                if (w_gv[o] && w_head[w_gi[o]].tail) r_pri[o] <= ~w_gi[o];
            end
        end
    end
endmodule

// File: tb/tb_simple_router_2x2.sv
// tb_simple_router_2x2: table vectors, directed corner sequences and random traffic vs a queue-based router model.
module tb_simple_router_2x2;
    import simple_router_2x2_pkg::*;
    localparam int D = 4;

    logic            clk = 1'b0;
    logic            rst_b;
    pkt_flit_t [1:0] pkt_in;
    pkt_flit_t [1:0] pkt_out;
    logic      [1:0] fifo_full;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    simple_router_2x2 #(.FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_b(rst_b), .pkt_in(pkt_in), .pkt_out(pkt_out), .fifo_full(fifo_full)
    );

    typedef struct {
        logic      rst;
        pkt_flit_t in0, in1, e0, e1;
        logic [1:0] ef;
    } vec_t;
    vec_t tbl[$];

    pkt_flit_t q[2][$];
    bit        m_act[2], m_tgt[2], m_pri[2];
    pkt_flit_t m_out[2];
    int        obs[$], obt[$];
    pkt_flit_t z;

    function automatic pkt_flit_t mk(bit h, bit t, bit v, int d, bit p, bit x);
        pkt_flit_t f;
        f.head = h; f.tail = t; f.valid = v; f.data = d; f.output_port_num = p; f.txn_id = x;
        return f;
    endfunction

    function automatic pkt_flit_t fl(int k, int base, bit p, bit x);
        return k < 4 ? mk(k == 0, k == 3, 1, base + k, p, x) : '0;
    endfunction

    function automatic pkt_flit_t ex(int k, int base, bit p, bit x);
        return k > 0 ? mk(k == 1, k == 4, 1, base + k - 1, p, x) : '0;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Router behaviour in terms of flit queues, locks and round-robin priority.
    task automatic model_step(input logic r, input pkt_flit_t a, input pkt_flit_t b);
        int sz[2];
        bit tg[2];
        int w;
        bit r0, r1;
        pkt_flit_t nf[2];
        pkt_flit_t f;
        nf[0] = a; nf[1] = b;
        if (r) begin
            for (int i = 0; i < 2; i++) begin
                q[i].delete(); m_act[i] = 0; m_tgt[i] = 0; m_pri[i] = 0; m_out[i] = '0;
            end
            return;
        end
        for (int i = 0; i < 2; i++) begin
            sz[i] = q[i].size();
            tg[i] = m_act[i] ? m_tgt[i] : (sz[i] > 0 ? q[i][0].output_port_num : 1'b0);
        end
        for (int o = 0; o < 2; o++) begin
            m_out[o] = '0;
            w = -1;
            for (int i = 0; i < 2; i++)
                if (m_act[i] && m_tgt[i] == o) w = sz[i] > 0 ? i : -2;
            if (w == -1) begin
                r0 = sz[0] > 0 && tg[0] == o;
                r1 = sz[1] > 0 && tg[1] == o;
                w = (r0 && r1) ? int'(m_pri[o]) : r0 ? 0 : r1 ? 1 : -1;
            end
            if (w >= 0) begin
                f = q[w].pop_front();
                m_out[o] = f;
                m_act[w] = !f.tail;
                m_tgt[w] = o[0];
                if (f.tail) m_pri[o] = (w == 0);
            end
        end
        for (int i = 0; i < 2; i++)
            if (nf[i].valid && sz[i] < D) q[i].push_back(nf[i]);
    endtask

    task automatic tick(input logic r, input pkt_flit_t a, input pkt_flit_t b);
        rst_b = r; pkt_in[0] = a; pkt_in[1] = b;
        @(posedge clk);
        model_step(r, a, b);
        #1;
    endtask

    task automatic chk_model(string nm);
        chk({nm, ".out0"}, 64'(pkt_out[0]), 64'(m_out[0]));
        chk({nm, ".out1"}, 64'(pkt_out[1]), 64'(m_out[1]));
        chk({nm, ".full"}, 64'(fifo_full), 64'({q[1].size() == D, q[0].size() == D}));
    endtask

    task automatic mtick(string nm, input logic r, input pkt_flit_t a, input pkt_flit_t b, input int po);
        tick(r, a, b);
        chk_model(nm);
        if (po >= 0 && pkt_out[po].valid) begin
            obs.push_back(int'(pkt_out[po].data));
            obt.push_back(int'(pkt_out[po].txn_id));
        end
    endtask

    initial begin
        int ed[$], et[$];
        z = '0;
        pkt_in = '0;
        rst_b = 1'b1;

        tbl.push_back('{1'b1, z, z, z, z, 2'b00});
        for (int k = 0; k < 5; k++) tbl.push_back('{1'b0, fl(k, 1, 0, 0), z, ex(k, 1, 0, 0), z, 2'b00});
        for (int k = 0; k < 5; k++) tbl.push_back('{1'b0, z, fl(k, 5, 0, 1), ex(k, 5, 0, 1), z, 2'b00});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{1'b0, fl(k, 9, 0, 0), fl(k, 13, 1, 1), ex(k, 9, 0, 0), ex(k, 13, 1, 1), 2'b00});
        foreach (tbl[n]) begin
            tick(tbl[n].rst, tbl[n].in0, tbl[n].in1);
            chk($sformatf("tbl%0d.out0", n), 64'(pkt_out[0]), 64'(tbl[n].e0));
            chk($sformatf("tbl%0d.out1", n), 64'(pkt_out[1]), 64'(tbl[n].e1));
            chk($sformatf("tbl%0d.full", n), 64'(fifo_full), 64'(tbl[n].ef));
        end

        // contention on port 0 from reset priority, then handover priority to input 1
        mtick("cont", 1, z, z, -1);
        obs.delete(); obt.delete();
        for (int k = 0; k < 14; k++)
            mtick("cont", 0,
                  k < 4 ? mk(k == 0, k == 3, 1, 100 + k, 0, 0) : k < 8 ? mk(k == 4, k == 7, 1, 196 + k, 0, 0) : z,
                  k < 4 ? mk(k <= 1, k == 3, 1, k + 1, 0, 1) : z, 0);
        ed = '{100, 101, 102, 103, 1, 2, 3, 4, 200, 201, 202, 203};
        et = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        chk("cont.count", 64'(obs.size()), 64'(ed.size()));
        foreach (ed[n]) if (n < obs.size()) begin
            chk($sformatf("cont.data%0d", n), 64'(obs[n]), 64'(ed[n]));
            chk($sformatf("cont.txn%0d", n), 64'(obt[n]), 64'(et[n]));
        end

        // overflow on input 1 while input 0 holds port 1
        mtick("ovf", 1, z, z, -1);
        obs.delete(); obt.delete();
        mtick("ovf", 0, mk(1, 0, 1, 50, 1, 0), z, 1);
        for (int k = 0; k < 6; k++) begin
            mtick("ovf", 0, z, mk(k == 0, k == 5, 1, 60 + k, 1, 1), 1);
            if (k == 3) chk("ovf.full_set", 64'(fifo_full), 64'(2'b10));
        end
        chk("ovf.full_held", 64'(fifo_full), 64'(2'b10));
        mtick("ovf", 0, mk(0, 1, 1, 51, 0, 0), z, 1);
        for (int k = 0; k < 6; k++) mtick("ovf", 0, z, z, 1);
        ed = '{50, 51, 60, 61, 62, 63};
        chk("ovf.count", 64'(obs.size()), 64'(ed.size()));
        foreach (ed[n]) if (n < obs.size()) chk($sformatf("ovf.data%0d", n), 64'(obs[n]), 64'(ed[n]));
        chk("ovf.full_clr", 64'(fifo_full), 64'(2'b00));

        // reset in the middle of a packet
        mtick("rstm", 0, mk(1, 0, 1, 70, 0, 0), z, -1);
        mtick("rstm", 0, mk(0, 0, 1, 71, 0, 0), z, -1);
        chk("rstm.pre", 64'(pkt_out[0].data), 64'(70));
        mtick("rstm", 1, mk(0, 0, 1, 72, 0, 0), z, -1);
        chk("rstm.valid", 64'({pkt_out[1].valid, pkt_out[0].valid}), 64'(2'b00));
        mtick("rstm", 0, mk(1, 1, 1, 80, 1, 1), z, -1);
        mtick("rstm", 0, z, z, -1);
        chk("rstm.new", 64'(pkt_out[1]), 64'(mk(1, 1, 1, 80, 1, 1)));
        chk("rstm.other", 64'(pkt_out[0].valid), 64'(0));

        for (int k = 0; k < 3000; k++) begin
            pkt_flit_t a, b;
            a = mk($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6,
                   int'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            b = mk($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6,
                   int'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            mtick("rnd", $urandom_range(0, 299) == 0, a, b, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
